// File: rtl/posit_extract_pipe.sv
`timescale 1ns/1ps
// Two-stage pipelined posit decoder with valid/ready handshake and a tag sideband.
// Stage 1 resolves sign, magnitude and regime run; stage 2 resolves scale, exponent and fraction.
module posit_extract_pipe #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned ES      = 2,
    parameter int unsigned FRAC_W  = 32,
    parameter int unsigned SCALE_W = 9,
    parameter int unsigned TAG_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NBITS-1:0]   in_data,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_sign,
    output logic               out_zero,
    output logic               out_nar,
    output logic [SCALE_W-1:0] out_scale,
    output logic [FRAC_W-1:0]  out_fraction,
    output logic [NBITS-2:0]   out_abs,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int unsigned B_W = NBITS - 1;       // body width below the sign
    localparam int unsigned M_W = $clog2(NBITS);   // holds a run length up to NBITS-1

    // pipeline occupancy
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic load2_c;

    // stage 1 registers
    logic             s1_sign_q, s1_sign_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_nar_q,  s1_nar_d;
    logic             s1_pol_q,  s1_pol_d;
    logic [M_W-1:0]   s1_run_q,  s1_run_d;
    logic [B_W-1:0]   s1_body_q, s1_body_d;
    logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;

    // stage 2 registers
    logic               s2_sign_q,  s2_sign_d;
    logic               s2_zero_q,  s2_zero_d;
    logic               s2_nar_q,   s2_nar_d;
    logic [SCALE_W-1:0] s2_scale_q, s2_scale_d;
    logic [FRAC_W-1:0]  s2_frac_q,  s2_frac_d;
    logic [B_W-1:0]     s2_abs_q,   s2_abs_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;

    // stage 1 combinational decode
    logic           dec1_sign;
    logic           dec1_zero;
    logic           dec1_nar;
    logic           dec1_pol;
    logic [B_W-1:0] dec1_body;
    logic [M_W-1:0] dec1_run;
    logic           run_done;

    // stage 2 combinational decode
    logic [M_W-1:0]     width_c;
    logic [B_W-1:0]     rem_c;
    logic [B_W-1:0]     frac_all_c;
    int                 k_v;
    int                 e_v;
    int                 scale_v;
    logic [SCALE_W-1:0] dec2_scale;
    logic [FRAC_W-1:0]  dec2_frac;

    assign load2_c  = ~v2_q | out_ready;
    assign in_ready = ~v1_q | ~v2_q | out_ready;

    // Magnitude low bits only depend on the operand's low bits, so the sign bit never enters the adder.
    always_comb begin
        dec1_sign = in_data[NBITS-1];
        dec1_zero = (in_data == '0);
        dec1_nar  = dec1_sign & (in_data[NBITS-2:0] == '0);
        dec1_body = dec1_sign ? (~in_data[NBITS-2:0] + B_W'(1)) : in_data[NBITS-2:0];
        dec1_pol  = dec1_body[B_W-1];
        dec1_run  = M_W'(B_W);
        run_done  = 1'b0;
        for (int i = int'(B_W) - 1; i >= 0; i--) begin
            if (!run_done && (dec1_body[i] != dec1_pol)) begin
                dec1_run = M_W'(int'(B_W) - 1 - i);
                run_done = 1'b1;
            end
        end
    end

    // Strip regime and terminator, then split exponent and fraction.
    always_comb begin
        k_v        = s1_pol_q ? (int'(s1_run_q) - 1) : -int'(s1_run_q);
        width_c    = (s1_run_q == M_W'(B_W)) ? s1_run_q : (s1_run_q + M_W'(1));
        rem_c      = s1_body_q << width_c;
        e_v        = 0;
        for (int i = 0; i < int'(ES); i++) begin
            e_v = (e_v << 1) | int'(rem_c[B_W-1-i]);
        end
        scale_v    = k_v * int'(2 ** ES) + e_v;
        frac_all_c = rem_c << ES;
        dec2_frac  = FRAC_W'({frac_all_c, FRAC_W'(0)} >> B_W);
        dec2_scale = SCALE_W'(scale_v);
        if (s1_zero_q | s1_nar_q) begin
            dec2_scale = '0;
            dec2_frac  = '0;
        end
    end

    // Next-state: stage 2 loads when empty or draining, stage 1 follows it.
    always_comb begin
        v1_d       = v1_q;
        v2_d       = v2_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        s1_pol_d   = s1_pol_q;
        s1_run_d   = s1_run_q;
        s1_body_d  = s1_body_q;
        s1_tag_d   = s1_tag_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_nar_d   = s2_nar_q;
        s2_scale_d = s2_scale_q;
        s2_frac_d  = s2_frac_q;
        s2_abs_d   = s2_abs_q;
        s2_tag_d   = s2_tag_q;

        if (in_ready) begin
            v1_d = in_valid;
        end
        if (load2_c) begin
            v2_d = v1_q;
        end
        if (in_valid && in_ready) begin
            s1_sign_d = dec1_sign;
            s1_zero_d = dec1_zero;
            s1_nar_d  = dec1_nar;
            s1_pol_d  = dec1_pol;
            s1_run_d  = dec1_run;
            s1_body_d = dec1_body;
            s1_tag_d  = in_tag;
        end
        if (load2_c && v1_q) begin
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = s1_zero_q;
            s2_nar_d   = s1_nar_q;
            s2_scale_d = dec2_scale;
            s2_frac_d  = dec2_frac;
            s2_abs_d   = s1_body_q;
            s2_tag_d   = s1_tag_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_pol_q   <= 1'b0;
            s1_run_q   <= '0;
            s1_body_q  <= '0;
            s1_tag_q   <= '0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_scale_q <= '0;
            s2_frac_q  <= '0;
            s2_abs_q   <= '0;
            s2_tag_q   <= '0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s1_pol_q   <= s1_pol_d;
            s1_run_q   <= s1_run_d;
            s1_body_q  <= s1_body_d;
            s1_tag_q   <= s1_tag_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_nar_q   <= s2_nar_d;
            s2_scale_q <= s2_scale_d;
            s2_frac_q  <= s2_frac_d;
            s2_abs_q   <= s2_abs_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid    = v2_q;
    assign out_sign     = s2_sign_q;
    assign out_zero     = s2_zero_q;
    assign out_nar      = s2_nar_q;
    assign out_scale    = s2_scale_q;
    assign out_fraction = s2_frac_q;
    assign out_abs      = s2_abs_q;
    assign out_tag      = s2_tag_q;

endmodule

// File: tb/tb_posit_extract_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench: a 32-bit/ES=2 and a 16-bit/ES=1 decoder checked against a
// bit-walking posit reference model under directed, backpressured and random traffic.
module tb_posit_extract_pipe;
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        nar;
        logic [31:0] scale;
        logic [63:0] frac;
        logic [63:0] abs;
        logic [7:0]  tag;
    } rec_t;
    localparam int RW = $bits(rec_t);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] a_in_data;
    logic [7:0]  a_in_tag;
    logic        a_in_valid, a_in_ready;
    logic        a_out_sign, a_out_zero, a_out_nar;
    logic [8:0]  a_out_scale;
    logic [31:0] a_out_fraction;
    logic [30:0] a_out_abs;
    logic [7:0]  a_out_tag;
    logic        a_out_valid, a_out_ready;

    logic [15:0] b_in_data;
    logic [7:0]  b_in_tag;
    logic        b_in_valid, b_in_ready;
    logic        b_out_sign, b_out_zero, b_out_nar;
    logic [5:0]  b_out_scale;
    logic [15:0] b_out_fraction;
    logic [14:0] b_out_abs;
    logic [7:0]  b_out_tag;
    logic        b_out_valid, b_out_ready;

    posit_extract_pipe dut32 (
        .clk(clk), .reset(reset),
        .in_data(a_in_data), .in_tag(a_in_tag), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_sign(a_out_sign), .out_zero(a_out_zero), .out_nar(a_out_nar),
        .out_scale(a_out_scale), .out_fraction(a_out_fraction), .out_abs(a_out_abs),
        .out_tag(a_out_tag), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    posit_extract_pipe #(.NBITS(16), .ES(1), .FRAC_W(16), .SCALE_W(6), .TAG_W(8)) dut16 (
        .clk(clk), .reset(reset),
        .in_data(b_in_data), .in_tag(b_in_tag), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_sign(b_out_sign), .out_zero(b_out_zero), .out_nar(b_out_nar),
        .out_scale(b_out_scale), .out_fraction(b_out_fraction), .out_abs(b_out_abs),
        .out_tag(b_out_tag), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int   checks = 0;
    int   failures = 0;
    int   occ [2];
    int   mode [2];
    rec_t q0 [$];
    rec_t q1 [$];
    bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic int nb_of(int id);  return (id != 0) ? 16 : 32; endfunction
    function automatic int es_of(int id);  return (id != 0) ? 1 : 2;   endfunction
    function automatic int fw_of(int id);  return (id != 0) ? 16 : 32; endfunction
    function automatic int sw_of(int id);  return (id != 0) ? 6 : 9;   endfunction

    // Reference: walk the posit bit string field by field.
    function automatic rec_t model(int id, logic [31:0] x, logic [7:0] tag);
        rec_t        r;
        int          nb, es, fw, sw, m, k, rem_n, e, fb;
        logic [63:0] u, body, rest, f;
        longint      s;
        logic        pol;
        nb = nb_of(id); es = es_of(id); fw = fw_of(id); sw = sw_of(id);
        r = '0;
        r.tag  = tag;
        r.sign = x[nb-1];
        r.zero = (x == 32'd0);
        r.nar  = (64'(x) == (64'd1 << (nb - 1)));
        u      = r.sign ? (((64'd1 << nb) - 64'(x)) & ((64'd1 << nb) - 64'd1)) : 64'(x);
        body   = u & ((64'd1 << (nb - 1)) - 64'd1);
        r.abs  = body;
        pol    = body[nb-2];
        m = 0;
        while (m < nb - 1 && body[nb-2-m] == pol) m++;
        k     = pol ? m - 1 : -m;
        rem_n = nb - 1 - (((m + 1) < (nb - 1)) ? (m + 1) : (nb - 1));
        rest  = body & ((64'd1 << rem_n) - 64'd1);
        if (rem_n >= es) begin
            e  = int'(rest >> (rem_n - es));
            fb = rem_n - es;
            f  = rest & ((64'd1 << fb) - 64'd1);
        end else begin
            e  = int'(rest << (es - rem_n));
            fb = 0;
            f  = 64'd0;
        end
        if (fb > 0) r.frac = f << (fw - fb);
        s = longint'(k) * (longint'(1) << es) + longint'(e);
        if (r.zero || r.nar) begin
            s = 0;
            r.frac = 64'd0;
        end
        r.scale = 32'(s & ((longint'(1) << sw) - 1));
        return r;
    endfunction

    function automatic rec_t mk(int id, logic s, logic z, logic n, longint scale,
                                logic [63:0] frac, logic [63:0] abs, logic [7:0] tag);
        rec_t r;
        r.sign = s; r.zero = z; r.nar = n;
        r.scale = 32'(scale & ((longint'(1) << sw_of(id)) - 1));
        r.frac = frac; r.abs = abs; r.tag = tag;
        return r;
    endfunction

    function automatic logic [31:0] rand_posit(int id);
        logic [63:0] v;
        int nb;
        nb = nb_of(id);
        v  = 64'($urandom);
        case ($urandom_range(0, 9))
            0: v = 64'd0;
            1: v = 64'd1 << (nb - 1);
            2: v = 64'd1;
            3: v = (64'd1 << (nb - 1)) - 64'd1;
            4: v = '1;
            5: v = v >> $urandom_range(1, 31);
            6: v = ~(v >> $urandom_range(1, 31));
            default: ;
        endcase
        return 32'(v & ((64'd1 << nb) - 64'd1));
    endfunction

    function automatic rec_t dut_out(int id);
        rec_t r;
        if (id == 0) begin
            r.sign = a_out_sign; r.zero = a_out_zero; r.nar = a_out_nar;
            r.scale = 32'(a_out_scale); r.frac = 64'(a_out_fraction);
            r.abs = 64'(a_out_abs); r.tag = a_out_tag;
        end else begin
            r.sign = b_out_sign; r.zero = b_out_zero; r.nar = b_out_nar;
            r.scale = 32'(b_out_scale); r.frac = 64'(b_out_fraction);
            r.abs = 64'(b_out_abs); r.tag = b_out_tag;
        end
        return r;
    endfunction

    function automatic logic ov(int id);  return (id != 0) ? b_out_valid : a_out_valid; endfunction

    task automatic check_rec(string name, int id, rec_t act, rec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: actual=%0h expected=%0h", name, id, RW'(act), RW'(exp));
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One input cycle: called at a falling edge, returns at the next one.
    task automatic drive(int id, logic v, logic [31:0] d, logic [7:0] t, rec_t e, output logic acc);
        logic rdy, ordy;
        if (id == 0) begin a_in_valid = v; a_in_data = d; a_in_tag = t; end
        else begin b_in_valid = v; b_in_data = d[15:0]; b_in_tag = t; end
        #1;
        rdy  = (id != 0) ? b_in_ready : a_in_ready;
        ordy = (id != 0) ? b_out_ready : a_out_ready;
        check_int($sformatf("in_ready dut%0d occ=%0d", id, occ[id]), int'(rdy),
                  int'((occ[id] < 2) || ordy));
        acc = v && rdy;
        if (acc) begin
            if (id == 0) q0.push_back(e); else q1.push_back(e);
            occ[id]++;
        end
        @(negedge clk);
    endtask

    task automatic idle(int id, int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(id, 1'b0, 32'd0, 8'd0, '0, acc);
    endtask

    task automatic send(int id, logic [31:0] d, logic [7:0] t, rec_t e);
        logic acc;
        int n;
        n = 0;
        do begin
            drive(id, 1'b1, d, t, e, acc);
            n++;
        end while (!acc && n < 100);
        if (!acc) check_int("send_timeout", 0, 1);
        if (id == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
    endtask

    task automatic send_lat(int id, logic [31:0] d, logic [7:0] t, rec_t e);
        send(id, d, t, e);
        #3;
        check_int("latency_cycle1_valid", int'(ov(id)), 0);
        @(negedge clk);
        #3;
        check_int("latency_cycle2_valid", int'(ov(id)), 1);
        @(negedge clk);
    endtask

    task automatic monitor(int id);
        rec_t act, exp, prev;
        logic stalled, v, r;
        stalled = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stalled = 1'b0;
                continue;
            end
            v   = ov(id);
            r   = (id != 0) ? b_out_ready : a_out_ready;
            act = dut_out(id);
            if (stalled) begin
                check_int("stall_valid_hold", int'(v), 1);
                check_rec("stall_data_hold", id, act, prev);
            end
            if (v && r) begin
                if ((id == 0 ? q0.size() : q1.size()) == 0) begin
                    check_rec("unexpected_output", id, act, '0);
                    if (act == '0) check_int("unexpected_output_valid", 1, 0);
                end else begin
                    exp = (id == 0) ? q0.pop_front() : q1.pop_front();
                    check_rec("result", id, act, exp);
                end
                if (occ[id] > 0) occ[id]--;
            end
            stalled = v && !r;
            prev = act;
        end
    endtask

    // out_ready generator per instance: 0 always, 1 fixed toggle pattern, 2 random, 3 held low
    initial begin
        int ph;
        ph = 0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode[0])
                1: begin a_out_ready = pat[ph % 6]; ph++; end
                2: a_out_ready = ($urandom_range(0, 2) != 0);
                3: a_out_ready = 1'b0;
                default: a_out_ready = 1'b1;
            endcase
            b_out_ready = (mode[1] == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  t;
        int          n;
        a_in_valid = 1'b0; a_in_data = '0; a_in_tag = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_tag = '0;
        occ[0] = 0; occ[1] = 0; mode[0] = 0; mode[1] = 0;
        reset = 1'b1;
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (2) @(negedge clk);
        check_int("reset_out_valid32", int'(a_out_valid), 0);
        check_int("reset_out_valid16", int'(b_out_valid), 0);
        check_rec("reset_data", 0, dut_out(0), '0);
        check_rec("reset_data", 1, dut_out(1), '0);
        reset = 1'b0;
        @(negedge clk);
        check_int("ready_after_reset32", int'(a_in_ready), 1);
        check_int("ready_after_reset16", int'(b_in_ready), 1);

        // 1.0 with latency, then the back-to-back stream and extremes
        send_lat(0, 32'h4000_0000, 8'd0, mk(0, 0, 0, 0, 0, 64'd0, 64'h4000_0000, 8'd0));
        send(0, 32'h4800_0000, 8'd1, mk(0, 0, 0, 0, 1, 64'd0, 64'h4800_0000, 8'd1));
        send(0, 32'h5000_0000, 8'd2, mk(0, 0, 0, 0, 2, 64'd0, 64'h5000_0000, 8'd2));
        send(0, 32'h4400_0000, 8'd3, mk(0, 0, 0, 0, 0, 64'h8000_0000, 64'h4400_0000, 8'd3));
        send(0, 32'hC000_0000, 8'd4, mk(0, 1, 0, 0, 0, 64'd0, 64'h4000_0000, 8'd4));
        send(0, 32'h0000_0001, 8'd5, mk(0, 0, 0, 0, -120, 64'd0, 64'h1, 8'd5));
        send(0, 32'h7FFF_FFFF, 8'd6, mk(0, 0, 0, 0, 120, 64'd0, 64'h7FFF_FFFF, 8'd6));
        send(0, 32'h0000_0000, 8'd7, mk(0, 0, 1, 0, 0, 64'd0, 64'd0, 8'd7));
        send(0, 32'h8000_0000, 8'd8, mk(0, 1, 0, 1, 0, 64'd0, 64'd0, 8'd8));
        idle(0, 4);

        // backpressure with the fixed toggle pattern
        mode[0] = 1;
        for (int i = 0; i < 5; i++) begin
            d = rand_posit(0);
            t = 8'(10 + i);
            send(0, d, t, model(0, d, t));
        end
        idle(0, 14);
        mode[0] = 3;
        idle(0, 2);

        // reset with two items in flight
        d = 32'h4800_0000;
        send(0, d, 8'd20, model(0, d, 8'd20));
        send(0, 32'h5000_0000, 8'd21, model(0, 32'h5000_0000, 8'd21));
        #1;
        check_int("inflight_valid", int'(a_out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check_int("async_reset_valid", int'(a_out_valid), 0);
        q0.delete();
        q1.delete();
        occ[0] = 0;
        occ[1] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mode[0] = 0;
        idle(0, 1);
        send_lat(0, 32'h4400_0000, 8'd22, mk(0, 0, 0, 0, 0, 64'h8000_0000, 64'h4400_0000, 8'd22));
        idle(0, 3);

        // random traffic with random backpressure
        mode[0] = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(0, 1);
            else begin
                d = rand_posit(0);
                t = 8'($urandom);
                send(0, d, t, model(0, d, t));
            end
        end
        mode[0] = 0;
        idle(0, 6);

        // narrower instance
        send_lat(1, 32'h5000, 8'h30, mk(1, 0, 0, 0, 1, 64'd0, 64'h5000, 8'h30));
        send(1, 32'h0001, 8'h31, mk(1, 0, 0, 0, -28, 64'd0, 64'h1, 8'h31));
        send(1, 32'h7FFF, 8'h32, mk(1, 0, 0, 0, 28, 64'd0, 64'h7FFF, 8'h32));
        mode[1] = 2;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1, 1);
            else begin
                d = rand_posit(1);
                t = 8'($urandom);
                send(1, d, t, model(1, d, t));
            end
        end
        mode[1] = 0;

        n = 0;
        while ((q0.size() + q1.size()) > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_pending32", q0.size(), 0);
        check_int("drain_pending16", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
